// File: rtl/multicycle_control_unit.sv
// Multicycle FSM controller for a 16-bit load/store core.
// Moore outputs come from the state plus a class decoded from IR and registered in DECODE.
module multicycle_control_unit #(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Instruction,
  input  logic        C,
  input  logic        Z,
  output logic        ir_load,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_op,
  output logic        Src_ALU_B,
  output logic        carry_in,
  output logic        RF_write_en,
  output logic [2:0]  rf_src,
  output logic        data_write_en,
  output logic        flag_OutR,
  output logic        flag_HLT,
  output logic        illegal_op
);

  typedef enum logic [2:0] {
    StFetch, StDecode, StExec, StMem, StWb, StHalt
  } state_e;

  typedef enum logic [4:0] {
    ClsIll, ClsAlu, ClsLhi, ClsLli, ClsLdr, ClsStr, ClsCmp, ClsAddi, ClsSubi,
    ClsMov, ClsBr, ClsJmp, ClsJal1, ClsJal2, ClsJr, ClsOutr, ClsHlt
  } cls_e;

  localparam logic [3:0] MemLast = 4'(MEM_WAIT);

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  logic [15:0] ir_q;
  logic        c_q, z_q;
  logic [3:0]  cnt_q, cnt_d;
  logic        flag_upd;
  logic        br_taken;
  logic        unused_ir;

  // Operand fields of IR are consumed by the datapath, not by this controller.
  assign unused_ir = ^ir_q[7:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StFetch;
      cls_q   <= ClsIll;
      ir_q    <= '0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (ir_load) ir_q <= Instruction;
      if (state_q == StDecode) cls_q <= cls_d;
      if (flag_upd) begin
        c_q <= C;
        z_q <= Z;
      end
    end
  end

  always_comb begin
    cls_d = ClsIll;
    case (ir_q[15:11])
      5'b00000: cls_d = ClsAlu;
      5'b00001: cls_d = ClsLhi;
      5'b00010: cls_d = ClsLli;
      5'b00011: cls_d = ClsLdr;
      5'b00101: cls_d = ClsStr;
      5'b00110: cls_d = ClsCmp;
      5'b00111: cls_d = ClsAddi;
      5'b01000: cls_d = ClsSubi;
      5'b01011: cls_d = ClsMov;
      5'b11000: cls_d = ClsBr;
      5'b10000: cls_d = ClsJmp;
      5'b10001: cls_d = ClsJal1;
      5'b10010: cls_d = ClsJal2;
      5'b10011: cls_d = ClsJr;
      5'b11100: begin
        case (ir_q[1:0])
          2'b00:   cls_d = ClsOutr;
          2'b01:   cls_d = ClsHlt;
          default: cls_d = ClsIll;
        endcase
      end
      default:  cls_d = ClsIll;
    endcase
  end

  always_comb begin
    br_taken = 1'b0;
    case (ir_q[10:8])
      3'b000:  br_taken = z_q;
      3'b001:  br_taken = ~z_q;
      3'b010:  br_taken = c_q;
      3'b011:  br_taken = ~c_q;
      3'b110:  br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    flag_upd      = 1'b0;
    ir_load       = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 2'b00;
    alu_op        = 2'b00;
    Src_ALU_B     = 1'b0;
    RF_write_en   = 1'b0;
    rf_src        = 3'b000;
    data_write_en = 1'b0;
    flag_OutR     = 1'b0;
    flag_HLT      = 1'b0;
    illegal_op    = 1'b0;

    unique case (state_q)
      StFetch: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
        state_d  = StDecode;
      end
      StDecode: state_d = StExec;
      StExec: begin
        state_d = StFetch;
        unique case (cls_q)
          ClsAlu:  begin alu_op = ir_q[1:0]; flag_upd = 1'b1; state_d = StWb; end
          ClsCmp:  begin alu_op = 2'b10; flag_upd = 1'b1; end
          ClsAddi: begin Src_ALU_B = 1'b1; flag_upd = 1'b1; state_d = StWb; end
          ClsSubi: begin
            alu_op    = 2'b10;
            Src_ALU_B = 1'b1;
            flag_upd  = 1'b1;
            state_d   = StWb;
          end
          ClsMov, ClsLhi, ClsLli: state_d = StWb;
          ClsLdr, ClsStr: begin state_d = StMem; cnt_d = '0; end
          ClsBr: begin
            if (br_taken) begin
              pc_write = 1'b1;
              pc_src   = 2'b01;
            end
          end
          ClsJmp:  begin pc_write = 1'b1; pc_src = 2'b01; end
          ClsJal1: begin
            pc_write    = 1'b1;
            pc_src      = 2'b01;
            RF_write_en = 1'b1;
            rf_src      = 3'b011;
          end
          ClsJal2: begin
            pc_write    = 1'b1;
            pc_src      = 2'b10;
            RF_write_en = 1'b1;
            rf_src      = 3'b011;
          end
          ClsJr:   begin pc_write = 1'b1; pc_src = 2'b11; end
          ClsOutr: flag_OutR = 1'b1;
          ClsHlt:  state_d = StHalt;
          default: illegal_op = 1'b1;
        endcase
      end
      StMem: begin
        if (cnt_q == MemLast) begin
          if (cls_q == ClsStr) begin
            data_write_en = 1'b1;
            state_d       = StFetch;
          end else begin
            state_d = StWb;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StWb: begin
        RF_write_en = 1'b1;
        state_d     = StFetch;
        case (cls_q)
          ClsLdr:  rf_src = 3'b001;
          ClsMov:  rf_src = 3'b010;
          ClsLhi:  rf_src = 3'b100;
          ClsLli:  rf_src = 3'b101;
          default: rf_src = 3'b000;
        endcase
      end
      StHalt: begin
        flag_HLT = 1'b1;
        state_d  = StHalt;
      end
      default: state_d = StFetch;
    endcase

    carry_in = (state_q != StHalt) & c_q;

    // Reset silences every output combinationally so no strobe escapes mid-abort.
    if (rst) begin
      ir_load       = 1'b0;
      pc_write      = 1'b0;
      pc_src        = 2'b00;
      alu_op        = 2'b00;
      Src_ALU_B     = 1'b0;
      carry_in      = 1'b0;
      RF_write_en   = 1'b0;
      rf_src        = 3'b000;
      data_write_en = 1'b0;
      flag_OutR     = 1'b0;
      flag_HLT      = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit with MEM_WAIT=2; per-cycle expected output
// vectors are queued when stimulus is driven and checked mid-cycle.
module tb_multicycle_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] Instruction;
  logic        C, Z;
  logic        ir_load, pc_write, Src_ALU_B, carry_in, RF_write_en;
  logic        data_write_en, flag_OutR, flag_HLT, illegal_op;
  logic [1:0]  pc_src, alu_op;
  logic [2:0]  rf_src;

  always #5 clk = ~clk;

  multicycle_control_unit #(.MEM_WAIT(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .Instruction   (Instruction),
    .C             (C),
    .Z             (Z),
    .ir_load       (ir_load),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .alu_op        (alu_op),
    .Src_ALU_B     (Src_ALU_B),
    .carry_in      (carry_in),
    .RF_write_en   (RF_write_en),
    .rf_src        (rf_src),
    .data_write_en (data_write_en),
    .flag_OutR     (flag_OutR),
    .flag_HLT      (flag_HLT),
    .illegal_op    (illegal_op)
  );

  // {ir_load, pc_write, pc_src, alu_op, Src_ALU_B, carry_in, RF_write_en, rf_src,
  //  data_write_en, flag_OutR, flag_HLT, illegal_op}
  logic [15:0] obs;
  assign obs = {ir_load, pc_write, pc_src, alu_op, Src_ALU_B, carry_in, RF_write_en,
                rf_src, data_write_en, flag_OutR, flag_HLT, illegal_op};

  localparam logic [15:0] VFetch  = 16'hC000;
  localparam logic [15:0] VTaken  = 16'h5000;
  localparam logic [15:0] VCin    = 16'h0100;

  int          compared   = 0;
  int          mismatched = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];
  logic        cm, zm;

  task automatic step(input string tag, input logic [15:0] base, input bit use_cin);
    logic [15:0] e;
    string       t;
    exp_q.push_back(base | ((use_cin && cm) ? VCin : 16'h0000));
    tag_q.push_back(tag);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    compared++;
    assert (obs === e) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", t, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  // FETCH, DECODE, EXEC of one instruction; C/Z are inverted outside EXEC so that
  // sampling them at the wrong time shows up in carry_in.
  task automatic fde(input string tag, input logic [15:0] ins, input logic [15:0] ex,
                     input logic c, input logic z, input bit upd);
    Instruction = ins;
    C = ~c;
    Z = ~z;
    step({tag, "_fetch"}, VFetch, 1'b1);
    Instruction = 16'($urandom);
    step({tag, "_decode"}, 16'h0000, 1'b1);
    C = c;
    Z = z;
    step({tag, "_exec"}, ex, 1'b1);
    if (upd) begin
      cm = c;
      zm = z;
    end
  endtask

  initial begin
    rst         = 1'b1;
    Instruction = 16'hE001;
    C           = 1'b1;
    Z           = 1'b1;
    cm          = 1'b0;
    zm          = 1'b0;
    @(posedge clk);
    #1;
    step("reset_hold", 16'h0000, 1'b0);
    rst = 1'b0;

    fde("add", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1);
    step("add_wb", 16'h0080, 1'b1);
    fde("adc", 16'h0001, 16'h0400, 1'b0, 1'b1, 1'b1);
    step("adc_wb", 16'h0080, 1'b1);
    fde("subi", 16'h4000, 16'h0A00, 1'b1, 1'b0, 1'b1);
    step("subi_wb", 16'h0080, 1'b1);
    fde("addi", 16'h3800, 16'h0200, 1'b1, 1'b1, 1'b1);
    step("addi_wb", 16'h0080, 1'b1);

    fde("ldr", 16'h1800, 16'h0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("ldr_mem", 16'h0000, 1'b1);
    step("ldr_wb", 16'h0090, 1'b1);
    fde("str", 16'h2800, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("str_mem0", 16'h0000, 1'b1);
    step("str_mem1", 16'h0000, 1'b1);
    step("str_mem2", 16'h0008, 1'b1);

    fde("cmp_a", 16'h3000, 16'h0800, 1'b0, 1'b1, 1'b1);
    fde("beq_a", 16'hC000, zm ? VTaken : 16'h0000, 1'b0, 1'b0, 1'b0);
    fde("bne_a", 16'hC100, !zm ? VTaken : 16'h0000, 1'b0, 1'b0, 1'b0);
    fde("bcs_a", 16'hC200, cm ? VTaken : 16'h0000, 1'b0, 1'b0, 1'b0);
    fde("bcc_a", 16'hC300, !cm ? VTaken : 16'h0000, 1'b0, 1'b0, 1'b0);
    fde("cmp_b", 16'h3000, 16'h0800, 1'b1, 1'b0, 1'b1);
    fde("beq_b", 16'hC000, zm ? VTaken : 16'h0000, 1'b1, 1'b1, 1'b0);
    fde("bne_b", 16'hC100, !zm ? VTaken : 16'h0000, 1'b1, 1'b1, 1'b0);
    fde("bcs_b", 16'hC200, cm ? VTaken : 16'h0000, 1'b1, 1'b1, 1'b0);
    fde("bcc_b", 16'hC300, !cm ? VTaken : 16'h0000, 1'b1, 1'b1, 1'b0);
    fde("b_always", 16'hC600, VTaken, 1'b0, 1'b0, 1'b0);
    fde("b_never", 16'hC400, 16'h0000, 1'b0, 1'b0, 1'b0);

    fde("jmp", 16'h8000, 16'h5000, 1'b0, 1'b0, 1'b0);
    fde("jal1", 16'h8800, 16'h50B0, 1'b0, 1'b0, 1'b0);
    fde("jal2", 16'h9000, 16'h60B0, 1'b0, 1'b0, 1'b0);
    fde("jr", 16'h9800, 16'h7000, 1'b0, 1'b0, 1'b0);

    fde("mov", 16'h5800, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("mov_wb", 16'h00A0, 1'b1);
    fde("lhi", 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("lhi_wb", 16'h00C0, 1'b1);
    fde("lli", 16'h1000, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("lli_wb", 16'h00D0, 1'b1);

    fde("outr", 16'hE000, 16'h0004, 1'b0, 1'b0, 1'b0);
    fde("undef", 16'h2000, 16'h0001, 1'b0, 1'b0, 1'b0);
    fde("sys2", 16'hE002, 16'h0001, 1'b0, 1'b0, 1'b0);
    fde("sys3", 16'hE003, 16'h0001, 1'b0, 1'b0, 1'b0);

    fde("str_abort", 16'h2800, 16'h0000, 1'b0, 1'b0, 1'b0);
    step("str_abort_mem0", 16'h0000, 1'b1);
    rst = 1'b1;
    step("rst_in_mem", 16'h0000, 1'b0);
    cm  = 1'b0;
    zm  = 1'b0;
    rst = 1'b0;

    fde("hlt", 16'hE001, 16'h0000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      Instruction = 16'($urandom);
      C = 1'($urandom);
      Z = 1'($urandom);
      step("halted", 16'h0002, 1'b0);
    end
    rst = 1'b1;
    step("rst_in_halt", 16'h0000, 1'b0);
    rst         = 1'b0;
    Instruction = 16'h0000;
    step("fetch_after_halt", VFetch, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter: MEM_WAIT, default 1, extra data-memory wait cycles per LDR/STR; legal range 0..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 Instruction  input  16  current instruction word; sampled only when ir_load=1.
REQ-005 C, Z  input  1 each  ALU carry/zero from datapath; sampled at end of EXEC for flag-setting ops.
REQ-006 ir_load  output  1  latch Instruction into internal IR this cycle.
REQ-007 pc_write, pc_src  output  1, 2  PC update; pc_src 00 PC+1, 01 label, 10 Rm, 11 Rd.
REQ-008 alu_op, Src_ALU_B, carry_in  output  2, 1, 1  00 ADD, 01 ADC, 10 SUB, 11 SBB; immediate B select; latched carry.
REQ-009 RF_write_en, rf_src  output  1, 3  register write; rf_src 000 ALU, 001 mem, 010 Rm, 011 PC, 100 LHI, 101 LLI.
REQ-010 data_write_en, flag_OutR, flag_HLT, illegal_op  output  1 each  store strobe, output-register strobe, halted, undefined-opcode pulse.

Function
REQ-011 States SHALL be FETCH, DECODE, EXEC, MEM, WB, HALT; all outputs Moore, from state plus IR.
REQ-012 FETCH: ir_load=1, pc_write=1, pc_src=00; next DECODE.
REQ-013 DECODE: IR[15:11] decoded into registered control; no output asserted; next EXEC.
REQ-014 Decode: 00000 ALU (alu_op=IR[1:0]), 00001 LHI, 00010 LLI, 00011 LDR, 00101 STR, 00110 CMP (SUB), 00111 ADDI, 01000 SUBI, 01011 MOV, 11000 branch (cond IR[10:8]), 10000 JMP, 10001 JAL1, 10010 JAL2, 10011 JR, 11100 system (IR[1:0] 00 OutR, 01 HLT).
REQ-015 EXEC ALU/CMP/ADDI/SUBI: alu_op driven (ADDI=00, SUBI/CMP=10), Src_ALU_B=1 for ADDI/SUBI; C_q,Z_q <= C,Z at end of cycle.
REQ-016 carry_in SHALL equal C_q at all times; C_q, Z_q change only per REQ-015.
REQ-017 Branch taken: 000 BEQ Z_q=1, 001 BNE Z_q=0, 010 BCS C_q=1, 011 BCC C_q=0, 110 B always, others never; taken => pc_write=1, pc_src=01 in EXEC.
REQ-018 EXEC jumps: JMP pc_src=01; JAL1 pc_src=01 and RF_write_en=1 rf_src=011; JAL2 pc_src=10 plus same link write; JR pc_src=11; pc_write=1 in each.
REQ-019 EXEC exits: ALU/ADDI/SUBI/MOV/LHI/LLI -> WB; LDR/STR -> MEM; CMP/branch/jump/OutR -> FETCH; HLT -> HALT.
REQ-020 OutR: flag_OutR=1 for exactly the EXEC cycle.
REQ-021 MEM lasts exactly MEM_WAIT+1 cycles, counted by internal counter cleared on entry.
REQ-022 STR: data_write_en=1 only in the final MEM cycle, then FETCH; LDR: no strobe, then WB.
REQ-023 WB: RF_write_en=1 one cycle; rf_src 000 ALU/ADDI/SUBI, 001 LDR, 010 MOV, 100 LHI, 101 LLI; next FETCH.
REQ-024 Undefined opcode or system IR[1:0] in {10,11}: illegal_op=1 in EXEC, no other strobe, next FETCH.
REQ-025 HALT: flag_HLT=1 continuously, all other outputs 0, Instruction ignored; exits only via rst.
REQ-026 Latency: ALU-class 4 cycles, CMP/branch/jump 3, LDR 4+MEM_WAIT+1, STR 3+MEM_WAIT+1.

Reset
REQ-027 rst=1 at an edge SHALL force state FETCH, IR=0, C_q=Z_q=0, counter=0; all outputs 0 while rst high, regardless of state.
REQ-028 rst mid-operation SHALL abort with no pending strobe; first cycle after rst low is FETCH.

Verification
REQ-029 Reset, ADD (00000_..._00), C=1 Z=0 in EXEC -> ir_load cycle 1, alu_op=00 cycle 3, RF_write_en=1 rf_src=000 cycle 4, carry_in=1 thereafter.
REQ-030 MEM_WAIT=2, LDR -> MEM cycles 4-6, RF_write_en=1 rf_src=001 cycle 7, FETCH cycle 8.
REQ-031 MEM_WAIT=2, STR -> data_write_en=1 cycle 6 only, RF_write_en never, FETCH cycle 7.
REQ-032 CMP with Z=1, then BEQ (1100_0000_...) -> pc_write=1 pc_src=01 in EXEC; BNE next -> pc_write=0 in EXEC.
REQ-033 JAL1 -> EXEC: pc_write=1 pc_src=01, RF_write_en=1 rf_src=011; next FETCH.
REQ-034 HLT (11100_..._01) -> flag_HLT=1 from cycle 4 persisting while Instruction toggles; rst during MEM of STR -> no data_write_en, FETCH after rst.
